// File: rtl/fsm_engine_pkg.sv
// fsm_engine_pkg: output-mode codes and entry field offsets shared by the FSM engine files
package fsm_engine_pkg;
    typedef enum logic {MODE_MEALY = 1'b0, MODE_REG = 1'b1} mode_e;
    localparam int OUT_LSB = 0;
endpackage

// File: rtl/fsm_table.sv
// fsm_table: transition/output table, one sync write port, one async read port,
// every entry cleared to RST_VAL on reset.
module fsm_table #(
    parameter int AW = 5,
    parameter int DW = 5,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= RST_VAL;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fsm_engine.sv
// fsm_engine: table-programmable FSM; lookup is {st, in}, entries are {next, out},
// out is either the Mealy lookup or its registered copy.
module fsm_engine
    import fsm_engine_pkg::*;
#(
    parameter int IN_W   = 2,
    parameter int OUT_W  = 2,
    parameter int ST_W   = 3,
    parameter int NUM_ST = 5,
    parameter int RST_ST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [ST_W+IN_W-1:0]  cfg_addr,
    input  logic [ST_W+OUT_W-1:0] cfg_data,
    input  logic                  run,
    input  logic                  mode,
    input  logic [IN_W-1:0]       in,
    output logic [OUT_W-1:0]      out,
    output logic [ST_W-1:0]       st,
    output logic                  err
);
    localparam int ENTRY_W  = ST_W + OUT_W;
    localparam int ADDR_W   = ST_W + IN_W;
    localparam int NEXT_LSB = OUT_LSB + OUT_W;
    localparam logic [ST_W-1:0] RST_CODE = ST_W'(RST_ST);

    logic [ENTRY_W-1:0] entry;
    logic [ST_W-1:0]    nxt;
    logic [OUT_W-1:0]   e_out;
    logic [OUT_W-1:0]   out_reg;
    logic               legal_move;

    fsm_table #(
        .AW(ADDR_W),
        .DW(ENTRY_W),
        .RST_VAL({RST_CODE, OUT_W'(0)})
    ) u_table (
        .clk  (clk),
        .rst  (rst),
        .we   (cfg_we),
        .waddr(cfg_addr),
        .wdata(cfg_data),
        .raddr({st, in}),
        .rdata(entry)
    );

    function automatic logic legal(input logic [ST_W-1:0] s);
        return {{(32-ST_W){1'b0}}, s} < 32'(NUM_ST);
    endfunction

    assign nxt        = entry[NEXT_LSB +: ST_W];
    assign e_out      = entry[OUT_LSB +: OUT_W];
    assign legal_move = legal(st) && legal(nxt);

    // An illegal current state or an illegal target both recover to RST_ST.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= RST_CODE;
            err     <= 1'b0;
            out_reg <= '0;
        end else begin
            out_reg <= run ? e_out : '0;
            if (run) begin
                st <= legal_move ? nxt : RST_CODE;
                if (!legal_move) err <= 1'b1;
            end
        end
    end

    assign out = (mode == MODE_REG) ? out_reg : (run ? e_out : '0);
endmodule

// File: tb/tb_fsm_engine.sv
// tb_fsm_engine: directed test-plan sequences plus random traffic, checked against
// an array-based behavioural model of the table-driven FSM.
module tb_fsm_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_addr = '0;
    logic [4:0] cfg_data = '0;
    logic       run = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] in = '0;
    logic [1:0] out;
    logic [2:0] st;
    logic       err;

    int n_chk = 0;
    int n_pass = 0;

    int m_tbl [32];
    int m_st, m_err, m_reg;
    logic [1:0] obs_out;

    fsm_engine dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .run(run), .mode(mode), .in(in),
        .out(out), .st(st), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int exp_out();
        if (mode) return m_reg;
        return run ? m_tbl[m_st * 4 + int'(in)] % 4 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_tbl[i] = 0;
        m_st = 0;
        m_err = 0;
        m_reg = 0;
    endtask

    // Lookup happens before the write lands, so coincident writes see the old entry.
    task automatic model_edge();
        int e;
        if (rst) begin
            model_reset();
            return;
        end
        e = m_tbl[m_st * 4 + int'(in)];
        m_reg = run ? e % 4 : 0;
        if (run) begin
            if (m_st >= 5 || e / 4 >= 5) begin
                m_st = 0;
                m_err = 1;
            end else m_st = e / 4;
        end
        if (cfg_we) m_tbl[int'(cfg_addr)] = int'(cfg_data);
    endtask

    task automatic cyc(input logic r, input logic we, input int a, input int d,
                       input logic rn, input logic md, input int i);
        @(negedge clk);
        rst = r;
        cfg_we = we;
        cfg_addr = 5'(a);
        cfg_data = 5'(d);
        run = rn;
        mode = md;
        in = 2'(i);
        #1;
        obs_out = out;
        check("out", 32'(out), 32'(exp_out()));
        check("st", 32'(st), 32'(m_st));
        check("err", 32'(err), 32'(m_err));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic md);
        cyc(0, 0, 0, 0, 0, md, 0);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        idle(0);

        // 1: reset table, in cycling
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, i);
        check("tp1_st", 32'(st), 0);
        check("tp1_err", 32'(err), 0);

        // 2: Mealy output with a programmed entry
        cyc(0, 1, 3, 4*4+2, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 3);
        check("tp2_out", 32'(obs_out), 2);
        check("tp2_st", 32'(st), 4);
        cyc(0, 1, 16, 4*4+1, 0, 0, 0);
        cyc(0, 1, 18, 4*4+1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 2);
        check("tp2_out2", 32'(obs_out), 1);
        check("tp2_st2", 32'(st), 4);

        // 3: registered output lags one cycle
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 4*4+2, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1, 3);
        check("tp3_out0", 32'(obs_out), 0);
        check("tp3_st", 32'(st), 4);
        idle(1);
        check("tp3_out1", 32'(obs_out), 2);

        // 4: illegal next state sets sticky err
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 6*4+3, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 1);
        check("tp4_st", 32'(st), 0);
        check("tp4_err", 32'(err), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        check("tp4_sticky", 32'(err), 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("tp4_clr", 32'(err), 0);

        // 5: coincident write uses old entry
        cyc(0, 1, 3, 4*4+2, 0, 0, 0);
        cyc(0, 1, 3, 2*4+1, 1, 0, 3);
        check("tp5_old_out", 32'(obs_out), 2);
        check("tp5_old_st", 32'(st), 4);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 3);
        check("tp5_new_out", 32'(obs_out), 1);
        check("tp5_new_st", 32'(st), 2);

        // 6: hold with run=0, reset beats run and write
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 4*4+2, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 3);
        check("tp6_hold_st", 32'(st), 4);
        check("tp6_hold_out", 32'(obs_out), 0);
        cyc(1, 1, 0, 3*4+3, 1, 0, 0);
        check("tp6_rst_st", 32'(st), 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("tp6_disc_out", 32'(obs_out), 0);
        check("tp6_disc_st", 32'(st), 0);
        cyc(0, 0, 0, 0, 1, 0, 3);
        check("tp6_clr_out", 32'(obs_out), 0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                ($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
